cic_dec_mc: RTL

- Multi-channel, time-interleaved CIC decimator with a runtime-selectable power-of-two decimation ratio.
- Next generation of the single-channel cic_dec. It serves CH channels from one shared integrator/comb datapath, with per-channel state held in register arrays.
- Sits between the ADC/front-end sample stream and downstream FIR compensation. Emits full-precision and rounded/truncated outputs tagged with a channel index.

---
 rtl/cic_dec_mc.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/cic_dec_mc.sv
// cic_dec_mc -- multi-channel, time-interleaved CIC decimator.
//
// One shared N-stage integrator / N-stage comb datapath serves CH channels
// whose samples arrive interleaved (ch0, ch1, .. ch CH-1, ch0, ..). Per-channel
// integrator and comb-delay state lives in packed register arrays indexed by
// the channel tag. Decimation ratio R = 2^rate_log2, latched while
// enable_cic is low.
//
// Optional build macro: CIC_STATUS_EN adds out_cnt, a 32-bit count of
// dout_vld pulses (cleared by reset and by enable_cic low).
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   enable_cic     run enable; low = soft clear (sync_err kept)
//   rate_log2      decimation log2; 0 or > LOG2_RMAX clamps to LOG2_RMAX
//   din_vld/sop    input beat valid / channel-0 marker
//   din            signed input sample
//   dout           full-precision comb output (BOUT bits)
//   dout_cut       rounded or truncated output (COUT bits)
//   dout_ch        channel tag of the current output word
//   dout_vld       one-cycle pulse per output word
//   sync_err       sticky: din_sop seen mid-frame
//   out_cnt        (CIC_STATUS_EN only) output word count
module cic_dec_mc #(
  parameter int CH         = 4,
  parameter int LOG2_RMAX  = 6,
  parameter int M          = 1,
  parameter int N          = 4,
  parameter int BIN        = 16,
  parameter int COUT       = 16,
  parameter int BOUT       = BIN + N*(LOG2_RMAX+M-1),
  parameter     CUT_METHOD = "ROUND",
  localparam int RW  = $clog2(LOG2_RMAX+1),
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_cic,
  input  logic [RW-1:0]          rate_log2,
  input  logic                   din_vld,
  input  logic                   din_sop,
  input  logic signed [BIN-1:0]  din,
  output logic signed [BOUT-1:0] dout,
  output logic signed [COUT-1:0] dout_cut,
  output logic [CHW-1:0]         dout_ch,
  output logic                   dout_vld,
  output logic                   sync_err
`ifdef CIC_STATUS_EN
  ,
  output logic [31:0]            out_cnt
`endif
);

  // stage 0 = boundary capture, 1..N = combs, N+1 = round add, N+2 = output
  localparam int STAGES = N + 2;
  localparam int SW     = $clog2(BOUT + 1);
  localparam bit ROUND  = (CUT_METHOD == "ROUND");

  generate
    if (COUT > BIN + N*M) begin : g_bad_cout
      $error("cic_dec_mc: COUT must not exceed BIN+N*M");
    end
  endgenerate

  logic                           clr;
  logic [RW-1:0]                  rate, rate_in;
  logic [LOG2_RMAX-1:0]           fcnt, fcnt_last;
  logic [CHW-1:0]                 ch_cnt, beat_ch;
  logic                           sop_bad, last_ch, bnd;
  logic [BOUT-1:0]                din_x, acc;
  logic [CH-1:0][N-1:0][BOUT-1:0] integ;
  logic [N-1:0][BOUT-1:0]         int_new;

  assign clr       = !rst_n || !enable_cic;
  assign rate_in   = (rate_log2 == '0 || rate_log2 > RW'(LOG2_RMAX)) ? RW'(LOG2_RMAX) : rate_log2;
  assign fcnt_last = LOG2_RMAX'((32'd1 << rate) - 32'd1);
  assign din_x     = {{(BOUT-BIN){din[BIN-1]}}, din};

  // A mid-frame sop realigns: the beat becomes channel 0 and counting resumes at 1.
  assign sop_bad = din_vld && din_sop && (ch_cnt != '0);
  assign beat_ch = din_sop ? '0 : ch_cnt;
  assign last_ch = (beat_ch == CHW'(CH-1));
  assign bnd     = enable_cic && din_vld && (fcnt == fcnt_last);

  // Whole integrator chain for the beat's channel settles in one cycle.
  always_comb begin
    int_new = '0;
    acc     = din_x;
    for (int k = 0; k < N; k++) begin
      acc        = integ[beat_ch][k] + acc;
      int_new[k] = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rate   <= rate_in;
      ch_cnt <= '0;
      fcnt   <= '0;
      integ  <= '0;
      if (!rst_n) sync_err <= 1'b0;
    end else if (din_vld) begin
      integ[beat_ch] <= int_new;
      ch_cnt         <= last_ch ? '0 : beat_ch + CHW'(1);
      if (last_ch) fcnt <= (fcnt == fcnt_last) ? '0 : fcnt + 1'b1;
      if (sop_bad) sync_err <= 1'b1;
    end
  end

  // ---------------- comb + cut pipeline ----------------
  logic [STAGES:0]                     vld_pipe;
  logic [N:0][BOUT-1:0]                cd;
  logic [STAGES-1:0][CHW-1:0]          ctag;
  logic [N-1:0][CH-1:0][M-1:0][BOUT-1:0] dly;
  logic [BOUT-1:0]                     x_q;
  logic signed [BOUT:0]                r_q, r_inc;
  logic signed [COUT-1:0]              r_cut;
  logic [SW-1:0]                       sh;

  // Growth at the active ratio minus output width; never negative because
  // COUT <= BIN+N*M is enforced at elaboration.
  assign sh = SW'(BIN + N*(int'(rate) + M - 1) - COUT);

  always_comb begin
    r_inc = '0;
    if (ROUND && sh != '0) r_inc[sh - 1'b1] = 1'b1;
  end

  assign r_cut = COUT'(r_q >>> sh);

  always_ff @(posedge clk) begin
    if (clr) begin
      vld_pipe <= '0;
      cd       <= '0;
      ctag     <= '0;
      dly      <= '0;
      x_q      <= '0;
      r_q      <= '0;
      dout     <= '0;
      dout_cut <= '0;
      dout_ch  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], bnd};
      if (bnd) begin
        cd[0]   <= int_new[N-1];
        ctag[0] <= beat_ch;
      end
      for (int k = 1; k <= N; k++) begin
        if (vld_pipe[k-1]) begin
          cd[k]   <= cd[k-1] - dly[k-1][ctag[k-1]][M-1];
          ctag[k] <= ctag[k-1];
          for (int m = M-1; m > 0; m--)
            dly[k-1][ctag[k-1]][m] <= dly[k-1][ctag[k-1]][m-1];
          dly[k-1][ctag[k-1]][0] <= cd[k-1];
        end
      end
      // Round add in one extra bit so +half never wraps the top value.
      if (vld_pipe[N]) begin
        x_q       <= cd[N];
        r_q       <= {cd[N][BOUT-1], cd[N]} + r_inc;
        ctag[N+1] <= ctag[N];
      end
      if (vld_pipe[N+1]) begin
        dout     <= x_q;
        dout_cut <= r_cut;
        dout_ch  <= ctag[N+1];
      end
    end
  end

  assign dout_vld = vld_pipe[STAGES];

`ifdef CIC_STATUS_EN
  always_ff @(posedge clk) begin
    if (clr)                    out_cnt <= '0;
    else if (vld_pipe[STAGES-1]) out_cnt <= out_cnt + 32'd1;
  end
`endif

endmodule
